// File: rtl/child_status_collector.sv
// Fan-in collector: round-robin arbitration of NUM_CHILD child records into one
// registered valid/ready output slot, with a flush/drain FSM for subtree quiesce.
module child_status_collector #(
  parameter int unsigned NUM_CHILD = 15,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_idx,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [CNT_W-1:0]            grant_cnt
);

  localparam int unsigned SLOTS = 1 << IDX_W;
  localparam int unsigned PTR_W = IDX_W + 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHILD - 1);
  localparam logic [PTR_W-1:0] NUM_CHILD_P = PTR_W'(NUM_CHILD);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [IDX_W-1:0]  rr_ptr;

  logic [SLOTS-1:0]  valid_pad;
  logic [DATA_W-1:0] data_arr [SLOTS];
  logic [SLOTS-1:0]  ready_pad_c;

  logic              slot_open_c;
  logic              grant_en_c;
  logic              gnt_found_c;
  logic              grant_fire_c;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [PTR_W-1:0]  cand_w;
  logic [IDX_W-1:0]  cand;

  // Pad valids/data to a power-of-two table so IDX_W-wide selects stay in range.
  assign valid_pad = SLOTS'(child_valid);

  for (genvar i = 0; i < SLOTS; i++) begin : g_data
    if (i < NUM_CHILD) begin : g_live
      assign data_arr[i] = child_data[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign data_arr[i] = '0;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_CHILD.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_CHILD; k++) begin
      cand_w = {1'b0, rr_ptr} + PTR_W'(k);
      if (cand_w >= NUM_CHILD_P) begin
        cand_w = cand_w - NUM_CHILD_P;
      end
      cand = cand_w[IDX_W-1:0];
      if (!gnt_found_c && valid_pad[cand]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand;
      end
    end
  end

  assign slot_open_c  = !out_valid || out_ready;
  assign grant_en_c   = !rst && (state == ST_RUN) && !flush_req && slot_open_c;
  assign grant_fire_c = grant_en_c && gnt_found_c;
  assign ready_pad_c  = grant_fire_c ? (SLOTS'(1) << gnt_idx_c) : '0;
  assign child_ready  = NUM_CHILD'(ready_pad_c);

  // Flush/drain next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (flush_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (slot_open_c) state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!flush_req) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state_nxt == ST_DRAINED);
    end
  end

  // Output slot, round-robin pointer and saturating grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else if (grant_fire_c) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[gnt_idx_c];
      out_idx   <= gnt_idx_c;
      rr_ptr    <= (gnt_idx_c == LAST_IDX) ? '0 : gnt_idx_c + IDX_W'(1);
      if (grant_cnt != CNT_MAX) begin
        grant_cnt <= grant_cnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_child_status_collector.sv
// Directed bench for child_status_collector: arbitration order, backpressure,
// flush/drain, reset mid-transfer and counter saturation (CNT_W=4 instance).
module tb_child_status_collector;

  localparam int NC = 15;
  localparam int DW = 16;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     child_valid;
  logic [NC*DW-1:0]  child_data;
  logic              out_ready;
  logic              flush_req;

  logic [NC-1:0]     child_ready, child_ready4;
  logic              out_valid, out_valid4;
  logic [DW-1:0]     out_data, out_data4;
  logic [IW-1:0]     out_idx, out_idx4;
  logic              flush_done, flush_done4;
  logic [15:0]       grant_cnt;
  logic [3:0]        grant_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  child_status_collector #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .flush_req(flush_req),
    .flush_done(flush_done), .grant_cnt(grant_cnt)
  );

  child_status_collector #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_idx(out_idx4), .flush_req(flush_req),
    .flush_done(flush_done4), .grant_cnt(grant_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    child_data[i*DW +: DW] = v;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [IW-1:0] idx);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_idx"},   32'(out_idx),   32'(idx));
  endtask

  initial begin
    rst         = 1'b1;
    child_valid = '1;
    child_data  = '0;
    out_ready   = 1'b0;
    flush_req   = 1'b0;
    for (int i = 0; i < NC; i++) set_data(i, 16'h1000 + 16'(i));

    // Reset: no grants while rst is high, all outputs cleared.
    #2;
    chk("rst_ready", 32'(child_ready), 32'h0);
    tick();
    tick();
    chk_slot("rst", 1'b0, 16'h0, 4'd0);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    chk("rst_cnt", 32'(grant_cnt), 32'h0);
    chk("rst_cnt4", 32'(grant_cnt4), 32'h0);

    // Test 1: single child 3.
    rst         = 1'b0;
    child_valid = 15'h0008;
    set_data(3, 16'hABCD);
    out_ready   = 1'b1;
    #1;
    chk("t1_ready", 32'(child_ready), 32'h0008);
    tick();
    child_valid = '0;
    chk_slot("t1", 1'b1, 16'hABCD, 4'd3);
    chk("t1_cnt", 32'(grant_cnt), 32'd1);
    tick();
    chk("t1_pop_valid", 32'(out_valid), 32'h0);

    // Test 2: all children valid from rr_ptr=0, 30 back-to-back grants.
    set_data(3, 16'h1003);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    child_valid = '1;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk("t2_ready", 32'(child_ready), 32'(1) << (k % NC));
      tick();
      chk_slot("t2", 1'b1, 16'h1000 + 16'(k % NC), 4'(k % NC));
    end
    chk("t2_cnt", 32'(grant_cnt), 32'd30);

    // Test 3: move rr_ptr to 14 via child 13, then wrap 14 -> 0.
    child_valid = 15'h2000;
    #1;
    chk("t3_ready13", 32'(child_ready), 32'h2000);
    tick();
    chk_slot("t3_g13", 1'b1, 16'h100D, 4'd13);
    child_valid = 15'h4001;
    #1;
    chk("t3_ready14", 32'(child_ready), 32'h4000);
    tick();
    chk_slot("t3_g14", 1'b1, 16'h100E, 4'd14);
    chk("t3_ready0", 32'(child_ready), 32'h0001);
    tick();
    chk_slot("t3_g0", 1'b1, 16'h1000, 4'd0);
    chk("t3_cnt", 32'(grant_cnt), 32'd33);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_stall_ready", 32'(child_ready), 32'h0);
      tick();
      chk_slot("t3_stall", 1'b1, 16'h1000, 4'd0);
      chk("t3_stall_cnt", 32'(grant_cnt), 32'd33);
    end

    // Test 4: fill slot with child 5, hold it, then flush and drain.
    child_valid = 15'h0020;
    set_data(5, 16'h5555);
    out_ready   = 1'b1;
    tick();
    chk_slot("t4_fill", 1'b1, 16'h5555, 4'd5);
    chk("t4_fill_cnt", 32'(grant_cnt), 32'd34);
    out_ready = 1'b0;
    flush_req = 1'b1;
    #1;
    chk("t4_req_ready", 32'(child_ready), 32'h0);
    tick();
    chk("t4_drain_done", 32'(flush_done), 32'h0);
    chk_slot("t4_drain", 1'b1, 16'h5555, 4'd5);
    out_ready = 1'b1;
    #1;
    chk("t4_drain_ready", 32'(child_ready), 32'h0);
    tick();
    chk("t4_drained_done", 32'(flush_done), 32'h1);
    chk("t4_drained_valid", 32'(out_valid), 32'h0);
    chk("t4_drained_ready", 32'(child_ready), 32'h0);
    tick();
    chk("t4_hold_done", 32'(flush_done), 32'h1);
    chk("t4_hold_cnt", 32'(grant_cnt), 32'd34);
    flush_req = 1'b0;
    #1;
    chk("t4_exit_ready", 32'(child_ready), 32'h0);
    tick();
    chk("t4_run_done", 32'(flush_done), 32'h0);
    chk("t4_resume_ready", 32'(child_ready), 32'h0020);
    tick();
    chk_slot("t4_resume", 1'b1, 16'h5555, 4'd5);
    chk("t4_resume_cnt", 32'(grant_cnt), 32'd35);

    // Test 5: reset while the slot is full and children are requesting.
    out_ready   = 1'b0;
    child_valid = 15'h0204;
    rst         = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(child_ready), 32'h0);
    tick();
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_cnt", 32'(grant_cnt), 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t5_first_ready", 32'(child_ready), 32'h0004);
    tick();
    chk_slot("t5_first", 1'b1, 16'h1002, 4'd2);
    chk("t5_first_cnt", 32'(grant_cnt), 32'd1);

    // Test 6: 19 more grants -> 20 total; the CNT_W=4 copy saturates at 15.
    child_valid = '1;
    for (int k = 0; k < 19; k++) tick();
    child_valid = '0;
    chk("t6_cnt16", 32'(grant_cnt), 32'd20);
    chk("t6_cnt4_sat", 32'(grant_cnt4), 32'd15);
    tick();
    chk("t6_cnt4_hold", 32'(grant_cnt4), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
